smc_counter_lite9: RTL and testbench
====================================

# smc_counter_lite9

Timing counter stage for the lite static memory controller. It loads chip-select leading-edge, wait-state and chip-select trailing-edge counts from the timing configuration at the start of each access, and reloads them at each beat of a multiple access. It counts them down under the state machine's enables and returns them to the state machine in smc_state_lite9. It also holds the per-access stores (CSLE, OETE) that the state machine and MAC use.

## Interface
- No parameters; widths fixed: CSLE/CSTE/OETE 2 bits, wait states 8 bits.
- sys_clk9  in  1  AHB system clock
- n_sys_reset9  in  1  reset; asynchronous, active-low
- valid_access9  in  1  state machine accepts a new access this cycle
- r_smc_currentstate9  in  5  registered SMC state (SMC_IDLE9/STORE9/LE9/RW9/FLOAT9 codes from smc_defs_lite9.v)
- smc_nextstate9  in  5  combinational next SMC state
- ws_enable9  in  1  wait-state decrement enable
- cste_enable9  in  1  trailing-edge decrement enable
- cfg_tcsle9  in  2  configured CS leading-edge delay
- cfg_tcste9  in  2  configured CS trailing-edge delay
- cfg_twait9  in  8  configured wait states
- cfg_toete9  in  2  configured read-strobe trailing-edge-before-CS time
- r_csle_count9  out  2  CS leading-edge counter
- r_cste_count9  out  2  CS trailing-edge counter
- r_ws_count9  out  8  wait-state counter
- r_csle_store9  out  2  CSLE value latched for the access
- r_oete_store9  out  2  OETE value latched for the access

## Operation
- Internal registers: r_ws_store9 [7:0] and r_cste_store9 [1:0]. Both are latched with r_csle_store9 and r_oete_store9.
- Store capture: on a clock edge with valid_access9=1, all four stores load from their cfg_* inputs. Otherwise all stores hold.
- beat_restart, a combinational term, is defined as ~valid_access9 & (A | B | C):
  - A: current ∈ {RW, FLOAT} and next == LE
  - B: current == FLOAT and next == RW
  - C: current == RW and next == RW and r_ws_count9 == 0 and r_cste_count9 == 0
- Counter update priority, per counter, per edge: valid_access9 load from cfg_*; then beat_restart load from store; then decrement; then hold.
- CSLE counter decrements when current == LE and count != 0.
- WS counter decrements when ws_enable9 = 1 and count != 0.
- CSTE counter decrements when cste_enable9 = 1 and count != 0.
- No counter wraps. A decrement at 0 holds at 0.
- During STORE and LE the WS counter holds, because ws_enable9 is 0 there. An RW phase therefore lasts r_ws_store9 + 1 cycles.
- An LE phase lasts exactly CSLE cycles. The state machine leaves LE when the count is < 2.
- A FLOAT phase lasts exactly CSTE cycles. The decrement occurs on the RW→FLOAT edge and on each FLOAT→FLOAT edge.
- Config inputs are sampled only on valid_access9 edges. Changes mid-access have no effect until the next accepted access.

## Timing
- Reset (n_sys_reset9 low, asynchronous): all counters and stores clear to 0 immediately and hold until the first edge after release.
- All outputs are registered. A value loaded on edge N is visible in the cycle after edge N.
- Latency from valid_access9 to r_csle_count9 = cfg_tcsle9: 1 edge. It is therefore visible in the STORE cycle.
- Simultaneous valid_access9 and beat_restart: cannot both be true, since beat_restart is gated by ~valid_access9.
- valid_access9 in RW with r_ws_count9 = 0 (back-to-back access): the cfg load overrides any decrement.
- Reset mid-access: counters clear. The state machine returns to IDLE on the same reset.
- Unknown or default state codes: beat_restart = 0 and no LE decrement. Counters change only on valid_access9 or on the enables.

## Test plan
- Reset: drive counters non-zero, then pulse n_sys_reset9 low mid-cycle -> all five outputs read 0 asynchronously, before the next clock edge.
- Single read, cfg tcsle=2, twait=3, tcste=1, toete=1:
  - valid_access edge -> csle=2, ws=3, cste=1, oete_store=1
  - LE for 2 cycles (csle 2→1→0)
  - RW for 4 cycles (ws 3→0)
  - FLOAT for 1 cycle (cste 0); smc_done high in FLOAT
- Zero timings (all cfg = 0) -> STORE then RW for one cycle, no LE/FLOAT; counters stay 0 throughout.
- Multiple access (mac_done=0), csle_store=1, twait=2 -> at end of RW, RW→LE with beat_restart reloads csle=1, ws=2, cste=store value; second beat timing is identical to the first.
- Back-to-back: valid_access in RW at ws=0 with new cfg twait=5 -> ws loads 5 on that edge; old stores are replaced.
- Config change mid-access: twait changes from 2 to 7 during RW -> the current access still finishes with ws from 2, and beat reloads use 2 until the next valid_access.

Source files
------------

// File: rtl/smc_counter_lite9_if.sv
// Signal bundle between the SMC state machine and the timing counter stage.
// valid_access9 is a one-cycle accept strobe with no back-pressure; counts are registered.
interface smc_counter_lite9_if;
  logic       valid_access9;
  logic [4:0] r_smc_currentstate9;
  logic [4:0] smc_nextstate9;
  logic       ws_enable9;
  logic       cste_enable9;
  logic [1:0] cfg_tcsle9;
  logic [1:0] cfg_tcste9;
  logic [7:0] cfg_twait9;
  logic [1:0] cfg_toete9;
  logic [1:0] r_csle_count9;
  logic [1:0] r_cste_count9;
  logic [7:0] r_ws_count9;
  logic [1:0] r_csle_store9;
  logic [1:0] r_oete_store9;

  modport master (
    output valid_access9, r_smc_currentstate9, smc_nextstate9, ws_enable9, cste_enable9,
    output cfg_tcsle9, cfg_tcste9, cfg_twait9, cfg_toete9,
    input  r_csle_count9, r_cste_count9, r_ws_count9, r_csle_store9, r_oete_store9
  );

  modport slave (
    input  valid_access9, r_smc_currentstate9, smc_nextstate9, ws_enable9, cste_enable9,
    input  cfg_tcsle9, cfg_tcste9, cfg_twait9, cfg_toete9,
    output r_csle_count9, r_cste_count9, r_ws_count9, r_csle_store9, r_oete_store9
  );
endinterface

// File: rtl/smc_counter_lite9.sv
// Timing counter stage of the lite SMC: loads CSLE/WS/CSTE counts per access,
// reloads them per beat of a multiple access and counts them down under the FSM enables.
module smc_counter_lite9 (
  input  logic                 sys_clk9,
  input  logic                 n_sys_reset9,
  smc_counter_lite9_if.slave   bus
);
  localparam logic [4:0] SMC_IDLE9  = 5'b00001;
  localparam logic [4:0] SMC_LE9    = 5'b00010;
  localparam logic [4:0] SMC_RW9    = 5'b00100;
  localparam logic [4:0] SMC_STORE9 = 5'b01000;
  localparam logic [4:0] SMC_FLOAT9 = 5'b10000;

  logic [1:0] csle_count, cste_count, csle_store, cste_store, oete_store;
  logic [7:0] ws_count, ws_store;
  logic       cur_rw, cur_float, cur_le, nxt_le, nxt_rw;
  logic       beat_restart, csle_dec, ws_dec, cste_dec;

  always_comb begin
    cur_rw    = (bus.r_smc_currentstate9 == SMC_RW9);
    cur_float = (bus.r_smc_currentstate9 == SMC_FLOAT9);
    cur_le    = (bus.r_smc_currentstate9 == SMC_LE9);
    nxt_le    = (bus.smc_nextstate9 == SMC_LE9);
    nxt_rw    = (bus.smc_nextstate9 == SMC_RW9);
    // A new beat starts when a multiple access loops back to LE or RW; an
    // accepted access always takes priority, so it masks the reload.
    beat_restart = ~bus.valid_access9 &
                   (((cur_rw | cur_float) & nxt_le) |
                    (cur_float & nxt_rw) |
                    (cur_rw & nxt_rw & (ws_count == 8'd0) & (cste_count == 2'd0)));
    csle_dec = cur_le & (csle_count != 2'd0);
    ws_dec   = bus.ws_enable9 & (ws_count != 8'd0);
    cste_dec = bus.cste_enable9 & (cste_count != 2'd0);
  end

  always_ff @(posedge sys_clk9 or negedge n_sys_reset9) begin
    if (!n_sys_reset9) begin
      csle_count <= 2'd0;
      cste_count <= 2'd0;
      ws_count   <= 8'd0;
    end else begin
      if (bus.valid_access9)  csle_count <= bus.cfg_tcsle9;
      else if (beat_restart)  csle_count <= csle_store;
      else if (csle_dec)      csle_count <= csle_count - 2'd1;

      if (bus.valid_access9)  ws_count <= bus.cfg_twait9;
      else if (beat_restart)  ws_count <= ws_store;
      else if (ws_dec)        ws_count <= ws_count - 8'd1;

      if (bus.valid_access9)  cste_count <= bus.cfg_tcste9;
      else if (beat_restart)  cste_count <= cste_store;
      else if (cste_dec)      cste_count <= cste_count - 2'd1;
    end
  end

  // Per-access stores: config is only sampled when an access is accepted.
  always_ff @(posedge sys_clk9 or negedge n_sys_reset9) begin
    if (!n_sys_reset9) begin
      csle_store <= 2'd0;
      cste_store <= 2'd0;
      oete_store <= 2'd0;
      ws_store   <= 8'd0;
    end else if (bus.valid_access9) begin
      csle_store <= bus.cfg_tcsle9;
      cste_store <= bus.cfg_tcste9;
      oete_store <= bus.cfg_toete9;
      ws_store   <= bus.cfg_twait9;
    end
  end

  assign bus.r_csle_count9 = csle_count;
  assign bus.r_cste_count9 = cste_count;
  assign bus.r_ws_count9   = ws_count;
  assign bus.r_csle_store9 = csle_store;
  assign bus.r_oete_store9 = oete_store;
endmodule

// File: tb/tb_smc_counter_lite9.sv
// Directed bench for smc_counter_lite9: the driver queues hand-computed expected
// counts per edge, and a monitor compares them on the following falling edge.
module tb_smc_counter_lite9;
  localparam logic [4:0] IDLE  = 5'b00001;
  localparam logic [4:0] LE    = 5'b00010;
  localparam logic [4:0] RW    = 5'b00100;
  localparam logic [4:0] STORE = 5'b01000;
  localparam logic [4:0] FLOAT = 5'b10000;

  logic sys_clk9;
  logic n_sys_reset9;
  smc_counter_lite9_if cnt_if ();

  smc_counter_lite9 dut (
    .sys_clk9     (sys_clk9),
    .n_sys_reset9 (n_sys_reset9),
    .bus          (cnt_if)
  );

  // clock / reset
  initial sys_clk9 = 1'b0;
  always #5 sys_clk9 = ~sys_clk9;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];

  function automatic logic [15:0] pk(input logic [1:0] csle, input logic [1:0] cste,
                                     input logic [7:0] ws, input logic [1:0] cs,
                                     input logic [1:0] os);
    return {csle, cste, ws, cs, os};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {cnt_if.r_csle_count9, cnt_if.r_cste_count9, cnt_if.r_ws_count9,
            cnt_if.r_csle_store9, cnt_if.r_oete_store9};
  endfunction

  task automatic chk(input string nm, input logic [15:0] exp);
    logic [15:0] act;
    act = dut_vec();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got csle=%0d cste=%0d ws=%0d cs_st=%0d oe_st=%0d want csle=%0d cste=%0d ws=%0d cs_st=%0d oe_st=%0d",
               nm, act[15:14], act[13:12], act[11:4], act[3:2], act[1:0],
               exp[15:14], exp[13:12], exp[11:4], exp[3:2], exp[1:0]);
    end
  endtask

  // monitor: every edge carrying a queued expectation is checked on the falling edge
  always @(negedge sys_clk9) begin
    if (exp_q.size() > 0) chk(name_q.pop_front(), exp_q.pop_front());
  end

  task automatic set_cfg(input logic [1:0] tcsle, input logic [7:0] twait,
                         input logic [1:0] tcste, input logic [1:0] toete);
    cnt_if.cfg_tcsle9 = tcsle;
    cnt_if.cfg_twait9 = twait;
    cnt_if.cfg_tcste9 = tcste;
    cnt_if.cfg_toete9 = toete;
  endtask

  // driver: one clock edge with the given FSM view; exp is the state after that edge
  task automatic cyc(input string nm, input logic [4:0] cur, input logic [4:0] nxt,
                     input logic va, input logic wse, input logic ce, input logic [15:0] exp);
    cnt_if.r_smc_currentstate9 = cur;
    cnt_if.smc_nextstate9      = nxt;
    cnt_if.valid_access9       = va;
    cnt_if.ws_enable9          = wse;
    cnt_if.cste_enable9        = ce;
    @(posedge sys_clk9);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge sys_clk9);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_sys_reset9 = 1'b0;
    cnt_if.valid_access9 = 1'b0;
    cnt_if.r_smc_currentstate9 = IDLE;
    cnt_if.smc_nextstate9 = IDLE;
    cnt_if.ws_enable9 = 1'b0;
    cnt_if.cste_enable9 = 1'b0;
    set_cfg(2'd3, 8'd9, 2'd3, 2'd3);
    repeat (2) @(negedge sys_clk9);
    #1;
    chk("reset_state", pk(0, 0, 0, 0, 0));
    n_sys_reset9 = 1'b1;
    cyc("idle_hold", IDLE, IDLE, 0, 0, 0, pk(0, 0, 0, 0, 0));

    // single read: tcsle=2 twait=3 tcste=1 toete=1
    set_cfg(2'd2, 8'd3, 2'd1, 2'd1);
    cyc("rd_accept",  IDLE,  STORE, 1, 0, 0, pk(2, 1, 3, 2, 1));
    cyc("rd_store",   STORE, LE,    0, 0, 0, pk(2, 1, 3, 2, 1));
    cyc("rd_le1",     LE,    LE,    0, 0, 0, pk(1, 1, 3, 2, 1));
    cyc("rd_le2",     LE,    RW,    0, 0, 0, pk(0, 1, 3, 2, 1));
    cyc("rd_rw1",     RW,    RW,    0, 1, 0, pk(0, 1, 2, 2, 1));
    cyc("rd_rw2",     RW,    RW,    0, 1, 0, pk(0, 1, 1, 2, 1));
    cyc("rd_rw3",     RW,    RW,    0, 1, 0, pk(0, 1, 0, 2, 1));
    cyc("rd_rw_fl",   RW,    FLOAT, 0, 1, 1, pk(0, 0, 0, 2, 1));
    cyc("rd_fl_idle", FLOAT, IDLE,  0, 0, 1, pk(0, 0, 0, 2, 1));
    cyc("rd_idle",    IDLE,  IDLE,  0, 0, 0, pk(0, 0, 0, 2, 1));

    // zero timings
    set_cfg(2'd0, 8'd0, 2'd0, 2'd0);
    cyc("z_accept",  IDLE,  STORE, 1, 0, 0, pk(0, 0, 0, 0, 0));
    cyc("z_store",   STORE, RW,    0, 0, 0, pk(0, 0, 0, 0, 0));
    cyc("z_rw_idle", RW,    IDLE,  0, 1, 0, pk(0, 0, 0, 0, 0));

    // multiple access: RW->LE reload, then FLOAT->RW reload
    set_cfg(2'd1, 8'd2, 2'd2, 2'd2);
    cyc("m_accept", IDLE,  STORE, 1, 0, 0, pk(1, 2, 2, 1, 2));
    cyc("m_store",  STORE, LE,    0, 0, 0, pk(1, 2, 2, 1, 2));
    cyc("m_le",     LE,    RW,    0, 0, 0, pk(0, 2, 2, 1, 2));
    cyc("m_rw1",    RW,    RW,    0, 1, 0, pk(0, 2, 1, 1, 2));
    cyc("m_rw2",    RW,    RW,    0, 1, 0, pk(0, 2, 0, 1, 2));
    cyc("m_rw_le",  RW,    LE,    0, 1, 0, pk(1, 2, 2, 1, 2));
    cyc("m2_le",    LE,    RW,    0, 0, 0, pk(0, 2, 2, 1, 2));
    cyc("m2_rw1",   RW,    RW,    0, 1, 0, pk(0, 2, 1, 1, 2));
    cyc("m2_rw2",   RW,    RW,    0, 1, 0, pk(0, 2, 0, 1, 2));
    cyc("m2_rw_fl", RW,    FLOAT, 0, 1, 1, pk(0, 1, 0, 1, 2));
    cyc("m2_fl_fl", FLOAT, FLOAT, 0, 0, 1, pk(0, 0, 0, 1, 2));
    cyc("m2_fl_rw", FLOAT, RW,    0, 0, 1, pk(1, 2, 2, 1, 2));
    cyc("m3_rw",    RW,    IDLE,  0, 1, 0, pk(1, 2, 1, 1, 2));

    // RW->RW beat restart once both ws and cste have run out
    set_cfg(2'd0, 8'd1, 2'd0, 2'd3);
    cyc("c_accept", IDLE,  STORE, 1, 0, 0, pk(0, 0, 1, 0, 3));
    cyc("c_store",  STORE, RW,    0, 0, 0, pk(0, 0, 1, 0, 3));
    cyc("c_rw1",    RW,    RW,    0, 1, 0, pk(0, 0, 0, 0, 3));
    cyc("c_reload", RW,    RW,    0, 1, 0, pk(0, 0, 1, 0, 3));
    cyc("c_rw_end", RW,    IDLE,  0, 1, 0, pk(0, 0, 0, 0, 3));

    // back-to-back: accept in RW at ws=0 overrides decrement and replaces stores
    set_cfg(2'd0, 8'd1, 2'd0, 2'd0);
    cyc("b_accept", IDLE,  STORE, 1, 0, 0, pk(0, 0, 1, 0, 0));
    cyc("b_store",  STORE, RW,    0, 0, 0, pk(0, 0, 1, 0, 0));
    cyc("b_rw",     RW,    RW,    0, 1, 0, pk(0, 0, 0, 0, 0));
    set_cfg(2'd3, 8'd5, 2'd3, 2'd2);
    cyc("b_b2b",    RW,    STORE, 1, 1, 1, pk(3, 3, 5, 3, 2));
    cyc("b_store2", STORE, LE,    0, 0, 0, pk(3, 3, 5, 3, 2));
    cyc("b_le",     LE,    LE,    0, 0, 0, pk(2, 3, 5, 3, 2));

    // config change mid-access has no effect until next accept
    set_cfg(2'd1, 8'd2, 2'd1, 2'd1);
    cyc("k_accept", IDLE,  STORE, 1, 0, 0, pk(1, 1, 2, 1, 1));
    cyc("k_store",  STORE, LE,    0, 0, 0, pk(1, 1, 2, 1, 1));
    cyc("k_le",     LE,    RW,    0, 0, 0, pk(0, 1, 2, 1, 1));
    set_cfg(2'd3, 8'd7, 2'd3, 2'd3);
    cyc("k_rw1",    RW,    RW,    0, 1, 0, pk(0, 1, 1, 1, 1));
    cyc("k_rw2",    RW,    RW,    0, 1, 0, pk(0, 1, 0, 1, 1));
    cyc("k_reload", RW,    LE,    0, 1, 0, pk(1, 1, 2, 1, 1));

    // unknown state codes: no reload, no LE decrement
    cyc("u_bad_le", 5'b00011, LE, 0, 0, 0, pk(1, 1, 2, 1, 1));
    cyc("u_zero",   5'b00000, RW, 0, 0, 0, pk(1, 1, 2, 1, 1));

    // asynchronous reset mid-cycle, held across an edge
    #2;
    n_sys_reset9 = 1'b0;
    #1;
    chk("async_reset", pk(0, 0, 0, 0, 0));
    @(posedge sys_clk9);
    #1;
    chk("reset_hold", pk(0, 0, 0, 0, 0));
    @(negedge sys_clk9);
    n_sys_reset9 = 1'b1;
    #1;
    cyc("post_reset", LE, LE, 0, 1, 1, pk(0, 0, 0, 0, 0));

    @(negedge sys_clk9);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
